// File: rtl/board_io_conditioner_pkg.sv
// ============================================================================
// Module      : board_io_conditioner_pkg
// Description : Board constants and shared types for the board I/O front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package board_io_conditioner_pkg;

    localparam int unsigned c_clk_hz            = 100_000_000;
    localparam int unsigned c_num_btn           = 5;
    localparam int unsigned c_num_sw            = 24;
    localparam int unsigned c_num_led           = 24;
    // 20 ms debounce window and 1 s long-press hold at the board clock.
    localparam int unsigned c_debounce_cycles   = c_clk_hz / 50;
    localparam int unsigned c_long_press_cycles = c_clk_hz;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_press;
    } btn_evt_t;

endpackage

`default_nettype wire

// File: rtl/board_io_conditioner_button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : One button channel: 2-flop synchroniser, debounce counter,
//               registered press/release pulses and, with IO_LONG_PRESS_EN,
//               a saturating hold counter driving a one-shot long-press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
    import board_io_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = c_debounce_cycles,
    parameter int unsigned LONG_PRESS_CYCLES = c_long_press_cycles
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_btn_raw,
    output btn_evt_t o_evt
);

    localparam int unsigned      c_cw       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0]  c_cnt_last = c_cw'(DEBOUNCE_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_level;
    logic [c_cw-1:0] r_cnt;
    logic            r_press;
    logic            r_rel;
    logic            w_long;
    btn_evt_t        r_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_meta  <= i_btn_raw;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            // Any return to the stable level restarts the window, which is what
            // rejects bounce without ever changing the level or pulsing.
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync;
                r_cnt   <= '0;
                r_press <= r_sync;
                r_rel   <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef IO_LONG_PRESS_EN
    localparam int unsigned      c_hw        = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [c_hw-1:0]  c_hold_max  = c_hw'(LONG_PRESS_CYCLES);
    localparam logic [c_hw-1:0]  c_hold_fire = c_hw'(LONG_PRESS_CYCLES - 1);

    logic [c_hw-1:0] r_hold;
    logic            r_long;

    // Saturation keeps the fire value from recurring, so one pulse per hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            if (!r_level) begin
                r_hold <= '0;
            end else if (r_hold != c_hold_max) begin
                r_hold <= r_hold + 1'b1;
            end
            r_long <= r_level && (r_hold == c_hold_fire);
        end
    end

    assign w_long = r_long;
`else
    assign w_long = 1'b0;
`endif

    // Output stage keeps level and all pulses aligned on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt.level      <= r_level;
            r_evt.press      <= r_press;
            r_evt.rel        <= r_rel;
            r_evt.long_press <= w_long;
        end
    end

    assign o_evt = r_evt;

endmodule

`default_nettype wire

// File: rtl/board_io_conditioner.sv
// ============================================================================
// Module      : board_io_conditioner
// Description : Board I/O front end: debounced buttons with press/release
//               (and optional long-press, macro IO_LONG_PRESS_EN) pulses,
//               synchronised switches and a CPU-writable LED register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_io_conditioner
    import board_io_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN           = c_num_btn,
    parameter int unsigned NUM_SW            = c_num_sw,
    parameter int unsigned NUM_LED           = c_num_led,
    parameter int unsigned DEBOUNCE_CYCLES   = c_debounce_cycles,
    parameter int unsigned LONG_PRESS_CYCLES = c_long_press_cycles
) (
    input  logic               fpga_clk,
    input  logic               fpga_rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long,
    output logic [NUM_SW-1:0]  sw_sync,
    input  logic               led_we,
    input  logic [NUM_LED-1:0] led_wdata,
    output logic [NUM_LED-1:0] led_out
);

    btn_evt_t           w_evt [NUM_BTN];
    logic [NUM_SW-1:0]  r_sw_meta;
    logic [NUM_SW-1:0]  r_sw_sync;
    logic [NUM_LED-1:0] r_led;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_debouncer (
            .clk       (fpga_clk),
            .rst       (fpga_rst),
            .i_btn_raw (btn_raw[i]),
            .o_evt     (w_evt[i])
        );

        assign btn_level[i]   = w_evt[i].level;
        assign btn_press[i]   = w_evt[i].press;
        assign btn_release[i] = w_evt[i].rel;
        assign btn_long[i]    = w_evt[i].long_press;
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_led     <= '0;
        end else begin
            r_sw_meta <= sw_raw;
            r_sw_sync <= r_sw_meta;
            if (led_we) begin
                r_led <= led_wdata;
            end
        end
    end

    assign sw_sync = r_sw_sync;
    assign led_out = r_led;

endmodule

`default_nettype wire
